// File: rtl/smoosh_pkg.sv
// Shared screen, colour and player-state definitions for the Smoosh Bros display path.
package smoosh_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  localparam logic [5:0] C_PLAYER = 6'b110000;
  localparam logic [5:0] C_GROUND = 6'b001100;
  localparam logic [5:0] C_BG     = 6'b000011;

  typedef enum logic {
    GROUND = 1'b0,
    AIR    = 1'b1
  } player_state_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for a bundle of asynchronous inputs.
module btn_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/player_renderer.sv
// Player sprite stage: per-frame position/jump physics from three buttons and
// a registered 6-bit pixel mux (player over ground over background).
module player_renderer
  import smoosh_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 48,
  parameter int GROUND_Y = 400,
  parameter int SPEED    = 4,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [9:0] col,
  input  logic [9:0] row,
  input  logic       vsync,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [5:0] rgb
);

  localparam int unsigned CW = 11;
  localparam logic [CW-1:0]       L_SPEED    = CW'(SPEED);
  localparam logic [CW-1:0]       L_SPR_W    = CW'(SPRITE_W);
  localparam logic [CW-1:0]       L_SPR_H    = CW'(SPRITE_H);
  localparam logic [CW-1:0]       L_GROUND_Y = CW'(GROUND_Y);
  localparam logic [CW-1:0]       L_X_MAX    = CW'(int'(H_ACTIVE) - SPRITE_W);
  localparam logic [9:0]          L_TOP      = 10'(GROUND_Y - SPRITE_H);
  localparam logic signed [CW-1:0] L_TOP_S   = CW'(GROUND_Y - SPRITE_H);
  localparam logic signed [7:0]   L_VY_JUMP  = 8'(GRAVITY - JUMP_V);
  localparam logic signed [7:0]   L_GRAV     = 8'(GRAVITY);
  localparam logic signed [7:0]   L_MAX_FALL = 8'(MAX_FALL);
  localparam logic [9:0]          L_X_RST    = 10'((int'(H_ACTIVE) - SPRITE_W) / 2);

  logic [2:0]          w_btn;
  logic                w_left, w_right, w_jump;
  logic                r_vsync_d;
  logic                w_tick;
  player_state_t       r_state, w_state_nxt;
  logic [9:0]          r_x, r_y, w_x_nxt, w_y_nxt;
  logic signed [7:0]   r_vy, w_vy_nxt, w_vy_inc;
  logic [CW-1:0]       w_x_add, w_x_sub;
  logic signed [CW-1:0] w_y_sum;
  logic                w_land;
  logic                w_in_x, w_in_y;
  logic [5:0]          r_rgb, w_rgb_nxt;

  btn_sync #(.WIDTH(3)) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({btn_jump, btn_right, btn_left}),
    .o_q (w_btn)
  );

  assign w_left  = w_btn[0];
  assign w_right = w_btn[1];
  assign w_jump  = w_btn[2];

  // Frame tick: registered vsync high last cycle, low now.
  assign w_tick   = r_vsync_d & ~vsync;

  assign w_x_add  = {1'b0, r_x} + L_SPEED;
  assign w_x_sub  = {1'b0, r_x} - L_SPEED;
  assign w_y_sum  = $signed({1'b0, r_y}) + $signed({{3{r_vy[7]}}, r_vy});
  assign w_land   = (w_y_sum >= L_TOP_S);
  assign w_vy_inc = r_vy + L_GRAV;

  // State and physics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_d <= 1'b0;
      r_state   <= GROUND;
      r_x       <= L_X_RST;
      r_y       <= L_TOP;
      r_vy      <= '0;
      r_rgb     <= '0;
    end else begin
      r_vsync_d <= vsync;
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_vy      <= w_vy_nxt;
      r_rgb     <= w_rgb_nxt;
    end
  end

  // Next-state: jump only leaves the ground, landing only returns to it.
  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      case (r_state)
        GROUND:  if (w_jump) w_state_nxt = AIR;
        AIR:     if (w_land) w_state_nxt = GROUND;
        default: w_state_nxt = GROUND;
      endcase
    end
  end

  // Physics outputs: horizontal and vertical both use pre-tick values.
  always_comb begin
    w_x_nxt  = r_x;
    w_y_nxt  = r_y;
    w_vy_nxt = r_vy;
    if (w_tick) begin
      if (w_left && !w_right) begin
        w_x_nxt = ({1'b0, r_x} < L_SPEED) ? 10'd0 : w_x_sub[9:0];
      end else if (w_right && !w_left) begin
        w_x_nxt = (w_x_add > L_X_MAX) ? L_X_MAX[9:0] : w_x_add[9:0];
      end
      case (r_state)
        GROUND: begin
          if (w_jump) begin
            w_y_nxt  = r_y - 10'(JUMP_V);
            w_vy_nxt = L_VY_JUMP;
          end
        end
        AIR: begin
          if (w_land) begin
            w_y_nxt  = L_TOP;
            w_vy_nxt = '0;
          end else begin
            w_y_nxt  = w_y_sum[9:0];
            w_vy_nxt = (w_vy_inc > L_MAX_FALL) ? L_MAX_FALL : w_vy_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_in_x = ({1'b0, col} >= {1'b0, r_x}) && ({1'b0, col} < ({1'b0, r_x} + L_SPR_W));
  assign w_in_y = ({1'b0, row} >= {1'b0, r_y}) && ({1'b0, row} < ({1'b0, r_y} + L_SPR_H));

  // Pixel mux in priority order.
  always_comb begin
    w_rgb_nxt = C_BG;
    if (!valid)                           w_rgb_nxt = '0;
    else if (w_in_x && w_in_y)            w_rgb_nxt = C_PLAYER;
    else if ({1'b0, row} >= L_GROUND_Y)   w_rgb_nxt = C_GROUND;
  end

  assign rgb = r_rgb;

endmodule
